// File: rtl/crossbar_pkg.sv
// Shared types and widths for the trigger crossbar: per-output routing entry and
// the commit FSM state encoding.
package crossbar_pkg;

  localparam int NUM_IN_DEFAULT = 12;
  // One extra code beyond the last input so "no input" is always representable
  localparam int SEL_W = $clog2(NUM_IN_DEFAULT + 1);

  typedef struct packed {
    logic [SEL_W-1:0] sel;
    logic             invert;
    logic             enable;
  } xbar_cfg_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BLANK = 1'b1
  } commit_state_t;

endpackage

// File: rtl/led_stretch.sv
// Activity stretcher: the LED rises the cycle after the source is seen high and
// falls once STRETCH_CYCLES consecutive low cycles have elapsed.
module led_stretch #(
  parameter int STRETCH_CYCLES = 2500000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  output logic led
);

  localparam int CW = $clog2(STRETCH_CYCLES + 1);

  logic [CW-1:0] idle_cnt;

  // idle_cnt saturates at STRETCH_CYCLES, so the LED drops one cycle after the last quiet cycle
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led      <= 1'b0;
      idle_cnt <= '0;
    end else if (src) begin
      led      <= 1'b1;
      idle_cnt <= '0;
    end else if (idle_cnt == CW'(STRETCH_CYCLES)) begin
      led <= 1'b0;
    end else begin
      idle_cnt <= idle_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/trigger_crossbar_sync.sv
// Registered trigger crossbar with shadow/active config, blanked commits and LED stretchers.
// Optional per-input rising-edge counters are built when CROSSBAR_EDGE_COUNT_EN is defined.
module trigger_crossbar_sync
  import crossbar_pkg::*;
#(
  parameter int NUM_IN         = 12,
  parameter int NUM_OUT        = 12,
  parameter int CNT_W          = 32,
  parameter int BLANK_CYCLES   = 4,
  parameter int STRETCH_CYCLES = 2500000
) (
  input  logic                       clk_250mhz,
  input  logic                       rst_n,
  input  logic [NUM_IN-1:0]          trig_in,
  output logic [NUM_OUT-1:0]         trig_out,
  input  logic                       cfg_wr_en,
  input  logic [$clog2(NUM_OUT)-1:0] cfg_wr_idx,
  input  logic [SEL_W-1:0]           cfg_wr_sel,
  input  logic                       cfg_wr_invert,
  input  logic                       cfg_wr_enable,
  input  logic                       cfg_commit,
  output logic                       cfg_busy,
  input  logic [$clog2(NUM_IN)-1:0]  cnt_rd_idx,
  output logic [CNT_W-1:0]           cnt_rd_data,
  input  logic                       cnt_clear,
  output logic [NUM_IN-1:0]          trig_in_led,
  output logic [NUM_OUT-1:0]         trig_out_led
);

  localparam int OW  = $clog2(NUM_OUT);
  localparam int BW  = $clog2(BLANK_CYCLES + 1);
  localparam int PAD = (1 << SEL_W) - NUM_IN;

  logic [NUM_IN-1:0]       in_reg;
  logic [(1<<SEL_W)-1:0]   in_pad;
  xbar_cfg_t               shadow_cfg [NUM_OUT];
  xbar_cfg_t               active_cfg [NUM_OUT];
  commit_state_t           state;
  logic [BW-1:0]           blank_cnt;
  logic [NUM_OUT-1:0]      routed;
  logic [NUM_OUT-1:0]      shadow_inv;
  logic [NUM_OUT-1:0]      active_inv;
  logic                    wr_in_range;

  // Zero-padding makes every selector code a legal index; codes past NUM_IN read 0
  assign in_pad      = {{PAD{1'b0}}, in_reg};
  assign wr_in_range = ({1'b0, cfg_wr_idx} < (OW+1)'(NUM_OUT));

  always_comb begin
    routed     = '0;
    shadow_inv = '0;
    active_inv = '0;
    for (int o = 0; o < NUM_OUT; o++) begin
      routed[o]     = (active_cfg[o].enable & in_pad[active_cfg[o].sel]) ^ active_cfg[o].invert;
      shadow_inv[o] = shadow_cfg[o].invert;
      active_inv[o] = active_cfg[o].invert;
    end
  end

  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) in_reg <= '0;
    else        in_reg <= trig_in;
  end

  // Shadow writes are accepted in any FSM state; a same-cycle commit sees the old contents
  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) begin
      for (int o = 0; o < NUM_OUT; o++) shadow_cfg[o] <= '0;
    end else if (cfg_wr_en && wr_in_range) begin
      shadow_cfg[cfg_wr_idx] <= '{sel: cfg_wr_sel, invert: cfg_wr_invert, enable: cfg_wr_enable};
    end
  end

  // While blanking, outputs sit at the newly committed invert level so downstream sees no glitch
  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) begin
      state     <= IDLE;
      blank_cnt <= '0;
      cfg_busy  <= 1'b0;
      trig_out  <= '0;
      for (int o = 0; o < NUM_OUT; o++) active_cfg[o] <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (cfg_commit) begin
            active_cfg <= shadow_cfg;
            state      <= BLANK;
            cfg_busy   <= 1'b1;
            blank_cnt  <= '0;
            trig_out   <= shadow_inv;
          end else begin
            trig_out <= routed;
          end
        end
        BLANK: begin
          if (blank_cnt == BW'(BLANK_CYCLES - 1)) begin
            state    <= IDLE;
            cfg_busy <= 1'b0;
            trig_out <= routed;
          end else begin
            blank_cnt <= blank_cnt + 1'b1;
            trig_out  <= active_inv;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CROSSBAR_EDGE_COUNT_EN
  localparam int IW = $clog2(NUM_IN);

  logic [NUM_IN-1:0] in_prev;
  logic [CNT_W-1:0]  edge_cnt [NUM_IN];
  logic              rd_in_range;

  assign rd_in_range = ({1'b0, cnt_rd_idx} < (IW+1)'(NUM_IN));

  // Clear wins over a coincident edge, so that edge is dropped
  always_ff @(posedge clk_250mhz) begin
    if (!rst_n) begin
      in_prev     <= '0;
      cnt_rd_data <= '0;
      for (int i = 0; i < NUM_IN; i++) edge_cnt[i] <= '0;
    end else begin
      in_prev <= in_reg;
      for (int i = 0; i < NUM_IN; i++) begin
        if (cnt_clear)                     edge_cnt[i] <= '0;
        else if (in_reg[i] && !in_prev[i]) edge_cnt[i] <= edge_cnt[i] + 1'b1;
      end
      cnt_rd_data <= rd_in_range ? edge_cnt[cnt_rd_idx] : '0;
    end
  end
`else
  logic unused_cnt_inputs;

  assign unused_cnt_inputs = ^{cnt_clear, cnt_rd_idx};
  assign cnt_rd_data       = '0;
`endif

  for (genvar i = 0; i < NUM_IN; i++) begin : g_in_led
    led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_led (
      .clk   (clk_250mhz),
      .rst_n (rst_n),
      .src   (in_reg[i]),
      .led   (trig_in_led[i])
    );
  end

  for (genvar o = 0; o < NUM_OUT; o++) begin : g_out_led
    led_stretch #(.STRETCH_CYCLES(STRETCH_CYCLES)) u_led (
      .clk   (clk_250mhz),
      .rst_n (rst_n),
      .src   (trig_out[o]),
      .led   (trig_out_led[o])
    );
  end

endmodule

// File: tb/tb_trigger_crossbar_sync.sv
// Directed, table-driven bench for trigger_crossbar_sync (edge counters checked
// when CROSSBAR_EDGE_COUNT_EN is defined, otherwise the read port must stay 0).
module tb_trigger_crossbar_sync;
  import crossbar_pkg::*;

  localparam int NUM_IN         = 12;
  localparam int NUM_OUT        = 12;
  localparam int CNT_W          = 4;
  localparam int BLANK_CYCLES   = 4;
  localparam int STRETCH_CYCLES = 8;

  logic               clk_250mhz;
  logic               rst_n;
  logic [NUM_IN-1:0]  trig_in;
  logic [NUM_OUT-1:0] trig_out;
  logic               cfg_wr_en;
  logic [3:0]         cfg_wr_idx;
  logic [SEL_W-1:0]   cfg_wr_sel;
  logic               cfg_wr_invert;
  logic               cfg_wr_enable;
  logic               cfg_commit;
  logic               cfg_busy;
  logic [3:0]         cnt_rd_idx;
  logic [CNT_W-1:0]   cnt_rd_data;
  logic               cnt_clear;
  logic [NUM_IN-1:0]  trig_in_led;
  logic [NUM_OUT-1:0] trig_out_led;

  int checks   = 0;
  int failures = 0;

  trigger_crossbar_sync #(
    .NUM_IN         (NUM_IN),
    .NUM_OUT        (NUM_OUT),
    .CNT_W          (CNT_W),
    .BLANK_CYCLES   (BLANK_CYCLES),
    .STRETCH_CYCLES (STRETCH_CYCLES)
  ) dut (
    .clk_250mhz    (clk_250mhz),
    .rst_n         (rst_n),
    .trig_in       (trig_in),
    .trig_out      (trig_out),
    .cfg_wr_en     (cfg_wr_en),
    .cfg_wr_idx    (cfg_wr_idx),
    .cfg_wr_sel    (cfg_wr_sel),
    .cfg_wr_invert (cfg_wr_invert),
    .cfg_wr_enable (cfg_wr_enable),
    .cfg_commit    (cfg_commit),
    .cfg_busy      (cfg_busy),
    .cnt_rd_idx    (cnt_rd_idx),
    .cnt_rd_data   (cnt_rd_data),
    .cnt_clear     (cnt_clear),
    .trig_in_led   (trig_in_led),
    .trig_out_led  (trig_out_led)
  );

  initial clk_250mhz = 1'b0;
  always #2 clk_250mhz = ~clk_250mhz;

  typedef struct {
    string       name;
    logic [11:0] stim;
    logic [11:0] exp_out;
  } vec_t;

  vec_t vecs [6];

  task automatic tick();
    @(posedge clk_250mhz);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic [11:0] value);
    trig_in = value;
    tick();
    tick();
  endtask

  task automatic writeCfg(input int idx, input int sel, input logic inv, input logic en);
    cfg_wr_en     = 1'b1;
    cfg_wr_idx    = 4'(idx);
    cfg_wr_sel    = SEL_W'(sel);
    cfg_wr_invert = inv;
    cfg_wr_enable = en;
    tick();
    cfg_wr_en = 1'b0;
  endtask

  task automatic doCommit();
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    repeat (BLANK_CYCLES) tick();
  endtask

  task automatic pulseIn(input int idx);
    trig_in[idx] = 1'b1;
    tick();
    trig_in[idx] = 1'b0;
    tick();
  endtask

  initial begin
    #200000;
    failures++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    // out0=in0, out1=~in1, out2=in11, out3=in5, out4 disabled+inv, out5 sel out of range+inv, out6=in2
    vecs[0] = '{name: "v_zero",  stim: 12'h000, exp_out: 12'h032};
    vecs[1] = '{name: "v_all",   stim: 12'hFFF, exp_out: 12'h07D};
    vecs[2] = '{name: "v_b0b5",  stim: 12'h021, exp_out: 12'h03B};
    vecs[3] = '{name: "v_b2b11", stim: 12'h804, exp_out: 12'h076};
    vecs[4] = '{name: "v_b1",    stim: 12'h002, exp_out: 12'h030};
    vecs[5] = '{name: "v_mix",   stim: 12'h7DE, exp_out: 12'h070};

    rst_n         = 1'b0;
    trig_in       = '0;
    cfg_wr_en     = 1'b0;
    cfg_wr_idx    = '0;
    cfg_wr_sel    = '0;
    cfg_wr_invert = 1'b0;
    cfg_wr_enable = 1'b0;
    cfg_commit    = 1'b0;
    cnt_rd_idx    = '0;
    cnt_clear     = 1'b0;
    repeat (3) tick();

    checkOutput("reset_trig_out", 32'(trig_out), 32'h0);
    checkOutput("reset_busy", 32'(cfg_busy), 32'h0);
    checkOutput("reset_cnt_rd", 32'(cnt_rd_data), 32'h0);
    checkOutput("reset_in_led", 32'(trig_in_led), 32'h0);
    checkOutput("reset_out_led", 32'(trig_out_led), 32'h0);
    rst_n = 1'b1;

    applyStimulus(12'hFFF);
    checkOutput("default_cfg_out", 32'(trig_out), 32'h0);
    trig_in = '0;

    writeCfg(0, 0, 1'b0, 1'b1);
    writeCfg(1, 1, 1'b1, 1'b1);
    writeCfg(2, 11, 1'b0, 1'b1);
    writeCfg(3, 5, 1'b0, 1'b1);
    writeCfg(4, 5, 1'b1, 1'b0);
    writeCfg(5, 12, 1'b1, 1'b1);
    writeCfg(6, 2, 1'b0, 1'b1);
    writeCfg(13, 0, 1'b1, 1'b1);
    doCommit();

    for (int v = 0; v < 6; v++) begin
      applyStimulus(vecs[v].stim);
      checkOutput(vecs[v].name, 32'(trig_out), 32'(vecs[v].exp_out));
    end
    checkOutput("out5_led", 32'(trig_out_led[5]), 32'h1);

    // Out-of-range selector with invert must stay high regardless of inputs
    for (int k = 0; k < 8; k++) begin
      trig_in = 12'($urandom);
      tick();
      checkOutput("oor_sel_const", 32'(trig_out[5:4]), 32'h3);
    end

    // Routing latency: exactly two edges from trig_in to trig_out
    applyStimulus(12'h000);
    checkOutput("lat_pre", 32'(trig_out[3]), 32'h0);
    trig_in[5] = 1'b1;
    tick();
    checkOutput("lat_t1", 32'(trig_out[3]), 32'h0);
    tick();
    checkOutput("lat_t2_rise", 32'(trig_out[3]), 32'h1);

    writeCfg(3, 5, 1'b1, 1'b1);
    trig_in = '0;
    doCommit();
    tick();
    checkOutput("inv_pre", 32'(trig_out[3]), 32'h1);
    trig_in[5] = 1'b1;
    tick();
    checkOutput("inv_t1", 32'(trig_out[3]), 32'h1);
    tick();
    checkOutput("inv_t2_fall", 32'(trig_out[3]), 32'h0);

    // Blanking with trig_in[5] held high; a second commit mid-blank must be ignored
    writeCfg(3, 5, 1'b0, 1'b1);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    for (int k = 0; k < 6; k++) begin
      checkOutput("blank_out3", 32'(trig_out[3]), (k < 4) ? 32'h0 : 32'h1);
      checkOutput("blank_busy", 32'(cfg_busy), (k < 4) ? 32'h1 : 32'h0);
      if (k == 1) begin
        cfg_commit    = 1'b1;
        cfg_wr_en     = 1'b1;
        cfg_wr_idx    = 4'd3;
        cfg_wr_sel    = SEL_W'(5);
        cfg_wr_invert = 1'b1;
        cfg_wr_enable = 1'b1;
      end else if (k == 2) begin
        cfg_commit = 1'b0;
        cfg_wr_en  = 1'b0;
      end
      tick();
    end
    doCommit();
    checkOutput("blank_shadow_write", 32'(trig_out[3]), 32'h0);

    // Same-cycle write and commit: commit takes the pre-write shadow
    applyStimulus(12'h001);
    cfg_wr_en     = 1'b1;
    cfg_wr_idx    = 4'd0;
    cfg_wr_sel    = SEL_W'(7);
    cfg_wr_invert = 1'b0;
    cfg_wr_enable = 1'b1;
    cfg_commit    = 1'b1;
    tick();
    cfg_wr_en  = 1'b0;
    cfg_commit = 1'b0;
    repeat (BLANK_CYCLES) tick();
    checkOutput("same_cycle_old_sel", 32'(trig_out[0]), 32'h1);
    doCommit();
    checkOutput("same_cycle_new_sel", 32'(trig_out[0]), 32'h0);
    applyStimulus(12'h080);
    checkOutput("new_sel_routes", 32'(trig_out[0]), 32'h1);

    trig_in = '0;
    tick();
`ifdef CROSSBAR_EDGE_COUNT_EN
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    repeat (10) pulseIn(2);
    repeat (3) tick();
    cnt_rd_idx = 4'd2;
    tick();
    tick();
    checkOutput("cnt_ten", 32'(cnt_rd_data), 32'd10);
    cnt_rd_idx = 4'd3;
    tick();
    checkOutput("cnt_idx3", 32'(cnt_rd_data), 32'd0);
    cnt_rd_idx = 4'd13;
    tick();
    checkOutput("cnt_idx_oor", 32'(cnt_rd_data), 32'd0);

    cnt_rd_idx = 4'd2;
    cnt_clear  = 1'b1;
    tick();
    cnt_clear = 1'b0;
    repeat (17) pulseIn(2);
    repeat (3) tick();
    checkOutput("cnt_wrap", 32'(cnt_rd_data), 32'd1);

    trig_in = 12'h004;
    tick();
    cnt_clear = 1'b1;
    tick();
    cnt_clear = 1'b0;
    trig_in   = '0;
    repeat (3) tick();
    checkOutput("cnt_clear_edge", 32'(cnt_rd_data), 32'd0);
`else
    repeat (5) pulseIn(2);
    cnt_rd_idx = 4'd2;
    cnt_clear  = 1'b1;
    tick();
    cnt_clear = 1'b0;
    repeat (3) tick();
    checkOutput("cnt_disabled", 32'(cnt_rd_data), 32'd0);
`endif

    // LED stretch: one-cycle pulse on in_reg[9] gives nine LED-high cycles
    trig_in = '0;
    repeat (12) tick();
    checkOutput("led_idle", 32'(trig_in_led[9]), 32'h0);
    trig_in[9] = 1'b1;
    tick();
    trig_in[9] = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      checkOutput("led_stretch", 32'(trig_in_led[9]), (k >= 2 && k <= 10) ? 32'h1 : 32'h0);
      tick();
    end

    // Reset in the middle of blanking
    applyStimulus(12'hFFF);
    cfg_commit = 1'b1;
    tick();
    cfg_commit = 1'b0;
    tick();
    checkOutput("busy_before_reset", 32'(cfg_busy), 32'h1);
    rst_n = 1'b0;
    tick();
    checkOutput("rst_blank_busy", 32'(cfg_busy), 32'h0);
    checkOutput("rst_blank_out", 32'(trig_out), 32'h0);
    checkOutput("rst_blank_out_led", 32'(trig_out_led), 32'h0);
    checkOutput("rst_blank_in_led", 32'(trig_in_led), 32'h0);
    checkOutput("rst_blank_cnt", 32'(cnt_rd_data), 32'h0);
    rst_n = 1'b1;
    repeat (BLANK_CYCLES + 2) tick();
    checkOutput("post_rst_busy", 32'(cfg_busy), 32'h0);
    checkOutput("post_rst_default_cfg", 32'(trig_out), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
